// File: rtl/cmp_result_checker.sv
// Per-frame statistics stage behind the magnitude comparator: recomputes each compare,
// counts outcomes/errors/mismatches and max |A-B|, and holds one summary per frame.
module cmp_result_checker #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 8,
    localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_cmp,
    input  logic             frame_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] mism_cnt,
    output logic [WIDTH-1:0] max_diff
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   gt_q, gt_d, eq_q, eq_d, lt_q, lt_d, err_q, err_d, mism_q, mism_d;
    logic [WIDTH-1:0]   max_q, max_d;
    logic [CNT_W-1:0]   s_gt_q, s_gt_d, s_eq_q, s_eq_d, s_lt_q, s_lt_d;
    logic [CNT_W-1:0]   s_err_q, s_err_d, s_mism_q, s_mism_d;
    logic [WIDTH-1:0]   s_max_q, s_max_d;
    logic               out_valid_q, out_valid_d;

    logic [2:0]         ref_code;
    logic [WIDTH-1:0]   diff;
    logic               accept;
    logic [CNT_W-1:0]   gt_n, eq_n, lt_n, err_n, mism_n;
    logic [WIDTH-1:0]   max_n;

    assign in_ready = rst_n & (state_q == ACCUM);
    assign accept   = in_valid & in_ready;
    assign ref_code = {in_a > in_b, in_a == in_b, in_a < in_b};
    assign diff     = (in_a >= in_b) ? (in_a - in_b) : (in_b - in_a);

    // Accumulator values including the current sample, used both to continue and to close a frame.
    always_comb begin
        gt_n   = gt_q;
        eq_n   = eq_q;
        lt_n   = lt_q;
        err_n  = err_q;
        case (in_cmp)
            3'b100:  gt_n  = gt_q + CNT_W'(1);
            3'b010:  eq_n  = eq_q + CNT_W'(1);
            3'b001:  lt_n  = lt_q + CNT_W'(1);
            default: err_n = err_q + CNT_W'(1);
        endcase
        mism_n = mism_q + CNT_W'(in_cmp != ref_code);
        max_n  = (diff > max_q) ? diff : max_q;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gt_d        = gt_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        err_d       = err_q;
        mism_d      = mism_q;
        max_d       = max_q;
        s_gt_d      = s_gt_q;
        s_eq_d      = s_eq_q;
        s_lt_d      = s_lt_q;
        s_err_d     = s_err_q;
        s_mism_d    = s_mism_q;
        s_max_d     = s_max_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ACCUM: begin
                if (frame_clear || (accept && idx_q == LAST_IDX)) begin
                    idx_d  = '0;
                    gt_d   = '0;
                    eq_d   = '0;
                    lt_d   = '0;
                    err_d  = '0;
                    mism_d = '0;
                    max_d  = '0;
                end else if (accept) begin
                    idx_d  = idx_q + CNT_W'(1);
                    gt_d   = gt_n;
                    eq_d   = eq_n;
                    lt_d   = lt_n;
                    err_d  = err_n;
                    mism_d = mism_n;
                    max_d  = max_n;
                end
                if (!frame_clear && accept && idx_q == LAST_IDX) begin
                    s_gt_d      = gt_n;
                    s_eq_d      = eq_n;
                    s_lt_d      = lt_n;
                    s_err_d     = err_n;
                    s_mism_d    = mism_n;
                    s_max_d     = max_n;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            idx_q       <= '0;
            gt_q        <= '0;
            eq_q        <= '0;
            lt_q        <= '0;
            err_q       <= '0;
            mism_q      <= '0;
            max_q       <= '0;
            s_gt_q      <= '0;
            s_eq_q      <= '0;
            s_lt_q      <= '0;
            s_err_q     <= '0;
            s_mism_q    <= '0;
            s_max_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gt_q        <= gt_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
            err_q       <= err_d;
            mism_q      <= mism_d;
            max_q       <= max_d;
            s_gt_q      <= s_gt_d;
            s_eq_q      <= s_eq_d;
            s_lt_q      <= s_lt_d;
            s_err_q     <= s_err_d;
            s_mism_q    <= s_mism_d;
            s_max_q     <= s_max_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign gt_cnt    = s_gt_q;
    assign eq_cnt    = s_eq_q;
    assign lt_cnt    = s_lt_q;
    assign err_cnt   = s_err_q;
    assign mism_cnt  = s_mism_q;
    assign max_diff  = s_max_q;

endmodule

// File: tb/tb_cmp_result_checker.sv
// Directed and randomized bench for cmp_result_checker against a queue-based frame model.
module tb_cmp_result_checker;

    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_cmp;
    logic             frame_clear;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt, err_cnt, mism_cnt;
    logic [WIDTH-1:0] max_diff;

    cmp_result_checker #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cmp(in_cmp), .frame_clear(frame_clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .err_cnt(err_cnt),
        .mism_cnt(mism_cnt), .max_diff(max_diff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int a; int b; int c; } samp_t;
    samp_t q[$];
    bit    m_hold;
    int    m_gt, m_eq, m_lt, m_err, m_mism, m_max;
    int    checks, passes, pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_hold = 0;
        {m_gt, m_eq, m_lt, m_err, m_mism, m_max} = '0;
    endtask

    // Frame statistics straight from the list of accepted samples.
    task automatic close_frame();
        {m_gt, m_eq, m_lt, m_err, m_mism, m_max} = '0;
        foreach (q[i]) begin
            int r, d;
            if (q[i].c == 4) m_gt++;
            else if (q[i].c == 2) m_eq++;
            else if (q[i].c == 1) m_lt++;
            else m_err++;
            r = (q[i].a > q[i].b) ? 4 : (q[i].a == q[i].b) ? 2 : 1;
            if (q[i].c != r) m_mism++;
            d = (q[i].a > q[i].b) ? q[i].a - q[i].b : q[i].b - q[i].a;
            if (d > m_max) m_max = d;
        end
        q.delete();
        m_hold = 1;
    endtask

    task automatic check_outputs();
        chk("in_ready", in_ready, (rst_n && !m_hold) ? 1 : 0);
        chk("out_valid", out_valid, m_hold ? 1 : 0);
        chk("gt_cnt", gt_cnt, m_gt);
        chk("eq_cnt", eq_cnt, m_eq);
        chk("lt_cnt", lt_cnt, m_lt);
        chk("err_cnt", err_cnt, m_err);
        chk("mism_cnt", mism_cnt, m_mism);
        chk("max_diff", max_diff, m_max);
    endtask

    task automatic cycle(output bit acc);
        @(negedge clk);
        if (!rst_n) model_reset();
        check_outputs();
        if (out_valid === 1'b1) pulses++;
        @(posedge clk);
        acc = 0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_hold) begin
            if (frame_clear) begin
                q.delete();
            end else if (in_valid) begin
                acc = 1;
                q.push_back('{a: int'(in_a), b: int'(in_b), c: int'(in_cmp)});
                if (q.size() == FRAME_LEN) close_frame();
            end
        end else if (out_ready) begin
            m_hold = 0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic send(input int a, input int b, input int c);
        bit acc;
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_a = WIDTH'(a);
        in_b = WIDTH'(b);
        in_cmp = 3'(c);
        for (int i = 0; i < 20 && !done; i++) begin
            cycle(acc);
            done = acc;
        end
        in_valid = 1'b0;
        chk("accept_within_budget", done, 1);
    endtask

    task automatic expect_sum(input string tag, input int g, input int e, input int l,
                              input int er, input int mm, input int md);
        chk({tag, "_gt"}, gt_cnt, g);
        chk({tag, "_eq"}, eq_cnt, e);
        chk({tag, "_lt"}, lt_cnt, l);
        chk({tag, "_err"}, err_cnt, er);
        chk({tag, "_mism"}, mism_cnt, mm);
        chk({tag, "_max"}, max_diff, md);
    endtask

    initial begin
        checks = 0; passes = 0; pulses = 0;
        model_reset();
        rst_n = 1'b0; in_valid = 1'b1; frame_clear = 1'b0; out_ready = 1'b1;
        in_a = 8'd3; in_b = 8'd1; in_cmp = 3'b100;

        // 1 reset with in_valid high
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        idle(2);
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(1);
        chk("post_reset_in_ready", in_ready, 1);

        // 2 clean frame
        pulses = 0;
        send(25, 10, 3'b100); send(5, 20, 3'b001); send(15, 15, 3'b010); send(255, 0, 3'b100);
        idle(3);
        chk("clean_pulses", pulses, 1);
        expect_sum("clean", 2, 1, 1, 0, 0, 255);

        // 3 malformed codes and mismatches
        send(0, 255, 3'b010); send(3, 3, 3'b011); send(7, 7, 3'b000); send(9, 4, 3'b100);
        idle(2);
        expect_sum("errs", 1, 1, 0, 2, 3, 255);

        // 4 backpressure: summary held, inputs refused
        out_ready = 1'b0;
        send(1, 0, 3'b100); send(2, 0, 3'b100); send(3, 0, 3'b100); send(4, 0, 3'b100);
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_cmp = 3'b010;
        idle(5);
        expect_sum("bp", 4, 0, 0, 0, 0, 4);
        out_ready = 1'b1;
        in_valid = 1'b0;
        idle(2);
        chk("bp_release_ready", in_ready, 1);

        // 5 abort with a concurrent sample
        send(100, 0, 3'b100); send(0, 200, 3'b001);
        frame_clear = 1'b1; in_valid = 1'b1;
        idle(1);
        frame_clear = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 2, 3'b001);
        idle(2);
        expect_sum("abort", 0, 0, 4, 0, 0, 1);

        // 6 reset mid-frame, then back-to-back frames
        send(8, 9, 3'b001); send(8, 9, 3'b001); send(8, 9, 3'b001);
        rst_n = 1'b0;
        #1;
        chk("rst_now_lt", lt_cnt, 0);
        chk("rst_now_in_ready", in_ready, 0);
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(8, 8, 3'b010);
        idle(2);
        expect_sum("after_rst", 0, 4, 0, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) send(i, 3, 3'b010);
        idle(3);
        chk("b2b_pulses", pulses, 2);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit acc;
            int a, b;
            a = $urandom_range(0, 255);
            b = ($urandom % 4 == 0) ? a : $urandom_range(0, 255);
            in_a = 8'(a);
            in_b = 8'(b);
            in_cmp = ($urandom % 5 == 0) ? 3'($urandom % 8)
                                         : {a > b, a == b, a < b};
            in_valid = ($urandom % 4) != 0;
            frame_clear = ($urandom % 16) == 0;
            out_ready = ($urandom % 3) != 0;
            cycle(acc);
        end
        in_valid = 1'b0; frame_clear = 1'b0; out_ready = 1'b1;
        idle(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
